direction_flags: RTL and testbench



---
 rtl/direction_flags_pkg.sv | 12 +
 rtl/direction_flags_if.sv | 26 ++
 rtl/direction_flags_mod_tile.sv | 28 ++
 rtl/direction_flags.sv | 101 ++++++++++
 tb/tb_direction_flags.sv | 120 ++++++++++++
 5 files changed

// File: rtl/direction_flags_pkg.sv
// Shared constants for the tile-grid direction classifier: default tile pitch
// and the one-hot direction codes used by the movement controller.
package direction_flags_pkg;

  localparam int TILE_PX = 12;

  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

endpackage

// File: rtl/direction_flags_if.sv
// Position-in / flags-out bundle between the sprite position source (master)
// and the direction classifier (slave).
interface direction_flags_if #(
  parameter int POS_W  = 9,
  parameter int FLAG_W = 3
);
  import direction_flags_pkg::*;

  logic [POS_W-1:0]  x;
  logic [POS_W-1:0]  y;
  logic [FLAG_W-1:0] flag_L;
  logic [FLAG_W-1:0] flag_R;
  logic [FLAG_W-1:0] flag_U;
  logic [FLAG_W-1:0] flag_D;

  modport master (
    output x, y,
    input  flag_L, flag_R, flag_U, flag_D
  );

  modport slave (
    input  x, y,
    output flag_L, flag_R, flag_U, flag_D
  );

endinterface

// File: rtl/direction_flags_mod_tile.sv
// Combinational pos % TILE by restoring subtraction of TILE<<k, largest shift
// first; no divider and no '%' operator.
module mod_tile
  import direction_flags_pkg::*;
#(
  parameter int POS_W = 9,
  parameter int TILE  = TILE_PX,
  parameter int REM_W = $clog2(TILE)
) (
  input  logic [POS_W-1:0] pos,
  output logic [REM_W-1:0] rem
);

  // Four guard bits cover TILE <= 14 shifted by up to POS_W-1 without wrap.
  localparam int W = POS_W + 4;

  logic [W-1:0] acc;

  always_comb begin
    acc = W'(pos);
    for (int k = POS_W - 1; k >= 0; k--) begin
      if (acc >= (W'(TILE) << k))
        acc = acc - (W'(TILE) << k);
    end
    rem = REM_W'(acc);
  end

endmodule

// File: rtl/direction_flags.sv
// Classifies sprite x/y against the tile grid and registers per-axis nearest-line
// flags. Define DIRFLAG_PIPE_EN for an extra remainder stage (latency 2).
module direction_flags
  import direction_flags_pkg::*;
#(
  parameter int POS_W  = 9,
  parameter int TILE   = TILE_PX,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  direction_flags_if.slave  bus
);

  localparam int REM_W = $clog2(TILE);
  localparam int RW1   = REM_W + 1;
  localparam int HALF  = TILE / 2;

  // Returns {lower/left flag, upper/right flag}; a tie goes to the right/lower line.
  function automatic logic [2*FLAG_W-1:0] enc(input logic [REM_W-1:0] rem);
    logic [RW1-1:0]    r;
    logic [FLAG_W-1:0] lo;
    logic [FLAG_W-1:0] hi;
    r  = {1'b0, rem};
    lo = '0;
    hi = '0;
    if (r < RW1'(HALF))
      lo = FLAG_W'(RW1'(HALF) - r);
    else
      hi = FLAG_W'(r - RW1'(HALF) + RW1'(1));
    return {lo, hi};
  endfunction

  logic [REM_W-1:0] rx_p0;
  logic [REM_W-1:0] ry_p0;

  // ---- stage 0: combinational remainders ----
  mod_tile #(.POS_W(POS_W), .TILE(TILE), .REM_W(REM_W)) u_mod_x (
    .pos (bus.x),
    .rem (rx_p0)
  );

  mod_tile #(.POS_W(POS_W), .TILE(TILE), .REM_W(REM_W)) u_mod_y (
    .pos (bus.y),
    .rem (ry_p0)
  );

`ifdef DIRFLAG_PIPE_EN
  logic [REM_W-1:0]    rx_p1;
  logic [REM_W-1:0]    ry_p1;
  logic [2*FLAG_W-1:0] fx_p2;
  logic [2*FLAG_W-1:0] fy_p2;

  // ---- stage 1: registered remainders ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p1 <= '0;
      ry_p1 <= '0;
    end else begin
      rx_p1 <= rx_p0;
      ry_p1 <= ry_p0;
    end
  end

  // ---- stage 2: encoded flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx_p2 <= '0;
      fy_p2 <= '0;
    end else begin
      fx_p2 <= enc(rx_p1);
      fy_p2 <= enc(ry_p1);
    end
  end

  assign bus.flag_L = fx_p2[2*FLAG_W-1:FLAG_W];
  assign bus.flag_R = fx_p2[FLAG_W-1:0];
  assign bus.flag_U = fy_p2[2*FLAG_W-1:FLAG_W];
  assign bus.flag_D = fy_p2[FLAG_W-1:0];
`else
  logic [2*FLAG_W-1:0] fx_p1;
  logic [2*FLAG_W-1:0] fy_p1;

  // ---- stage 1: encoded flags ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fx_p1 <= '0;
      fy_p1 <= '0;
    end else begin
      fx_p1 <= enc(rx_p0);
      fy_p1 <= enc(ry_p0);
    end
  end

  assign bus.flag_L = fx_p1[2*FLAG_W-1:FLAG_W];
  assign bus.flag_R = fx_p1[FLAG_W-1:0];
  assign bus.flag_U = fy_p1[2*FLAG_W-1:FLAG_W];
  assign bus.flag_D = fy_p1[FLAG_W-1:0];
`endif

endmodule

// File: tb/tb_direction_flags.sv
// Directed-vector bench for direction_flags; honours DIRFLAG_PIPE_EN for latency.
module tb_direction_flags;
  import direction_flags_pkg::*;

`ifdef DIRFLAG_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  direction_flags_if #(.POS_W(9), .FLAG_W(3)) dif ();

  direction_flags #(.POS_W(9), .TILE(TILE_PX), .FLAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_flags(input int p, output int lo, output int hi);
    int r;
    r = p % 12;
    if (r < 6) begin lo = 6 - r; hi = 0; end
    else       begin lo = 0;     hi = r - 5; end
  endfunction

  function automatic logic [3:0] dirs(input int l, input int u, input int r, input int d);
    return ((l != 0) ? DIR_L : 4'b0) | ((u != 0) ? DIR_U : 4'b0) |
           ((r != 0) ? DIR_R : 4'b0) | ((d != 0) ? DIR_D : 4'b0);
  endfunction

  task automatic check_flags(input string tag, input int el, input int er, input int eu, input int ed);
    chk({tag, ".L"}, 32'(dif.flag_L), 32'(el));
    chk({tag, ".R"}, 32'(dif.flag_R), 32'(er));
    chk({tag, ".U"}, 32'(dif.flag_U), 32'(eu));
    chk({tag, ".D"}, 32'(dif.flag_D), 32'(ed));
  endtask

  // Drive x/y, wait out the pipeline latency, then check at posedge+1.
  task automatic vec(input string tag, input int xv, input int yv,
                     input int el, input int er, input int eu, input int ed);
    dif.x = 9'(xv);
    dif.y = 9'(yv);
    repeat (LAT) @(posedge clk);
    #1;
    check_flags(tag, el, er, eu, ed);
  endtask

  initial begin
    int lo, hi, uo, dn;
    dif.x = '0;
    dif.y = '0;
    #1;
    check_flags("reset", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset_hold", 0, 0, 0, 0);
    rst = 1'b0;

    vec("rem8_2",    200, 230, 0, 3, 4, 0);
    vec("on_grid",     0,  12, 6, 0, 6, 0);
    vec("tie_x",       6,  17, 0, 1, 1, 0);
    vec("x11",        11,   0, 0, 6, 6, 0);
    vec("max",       511, 511, 0, 2, 0, 2);
    vec("rem5_tie",    5,  18, 1, 0, 0, 1);

    // Pipelined build: the result must not show after one edge, only after two.
    dif.x = 9'd0;
    dif.y = 9'd0;
    repeat (LAT) @(posedge clk);
    dif.x = 9'd11;
    @(posedge clk);
    #1;
    if (LAT == 2) chk("lat2_early.R", 32'(dif.flag_R), 32'd0);
    else          chk("lat1.R", 32'(dif.flag_R), 32'd6);
    if (LAT == 2) begin
      @(posedge clk);
      #1;
      chk("lat2.R", 32'(dif.flag_R), 32'd6);
    end

    for (int i = 0; i < 512; i++) begin
      int yv;
      yv = (i * 37 + 5) % 512;
      ref_flags(i, lo, hi);
      ref_flags(yv, uo, dn);
      vec($sformatf("sweep%0d", i), i, yv, lo, hi, uo, dn);
      chk("inv_x", 32'((dif.flag_L != 0) + (dif.flag_R != 0)), 32'd1);
      chk("inv_y", 32'((dif.flag_U != 0) + (dif.flag_D != 0)), 32'd1);
      chk("dirs", 32'(dirs(dif.flag_L, dif.flag_U, dif.flag_R, dif.flag_D)),
          32'(dirs(lo, uo, hi, dn)));
      if (i == 300) begin
        #2 rst = 1'b1;
        #1;
        check_flags("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        vec("post_rst", 200, 230, 0, 3, 4, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
